// File: rtl/unstripe_lane_sched_pkg.sv
// ---------------------------------------------------------------------------
// unstripe_pkg
//   Shared definitions for the byte-unstriping lane scheduler: the scheduler
//   state encoding, default widths and reset constants.
//   Optional feature macro used by the scheduler: UNSTRIPE_UNDERRUN_CNT_EN.
// ---------------------------------------------------------------------------
package unstripe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;
  localparam int UNDERRUN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN0  = 2'd2,
    RUN1  = 2'd3
  } sched_state_e;

  localparam sched_state_e STATE_RST    = IDLE;
  localparam logic         VALID_RST    = 1'b0;
  localparam logic [UNDERRUN_W-1:0] UNDERRUN_MAX = '1;

  // Saturating increment for the 8-bit stall counter.
  function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
    return (v == UNDERRUN_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/unstripe_lane_sched_if.sv
// ---------------------------------------------------------------------------
// unstripe_lane_sched_if
//   Bundles the two show-ahead lane FIFO heads (data/empty/pop) and the
//   merged output stream (data_out/valid_out/out_ready).
//   master : scheduler side (consumes lane heads, produces the output stream)
//   slave  : environment side (lane FIFOs and downstream sink)
// ---------------------------------------------------------------------------
interface unstripe_lane_sched_if
  import unstripe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] lane0_data;
  logic              lane0_empty;
  logic              lane0_pop;
  logic [DATA_W-1:0] lane1_data;
  logic              lane1_empty;
  logic              lane1_pop;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;

  modport master (
    input  lane0_data, lane0_empty, lane1_data, lane1_empty, out_ready,
    output lane0_pop, lane1_pop, data_out, valid_out
  );

  modport slave (
    output lane0_data, lane0_empty, lane1_data, lane1_empty, out_ready,
    input  lane0_pop, lane1_pop, data_out, valid_out
  );
endinterface

// File: rtl/unstripe_lane_sched.sv
// ---------------------------------------------------------------------------
// unstripe_lane_sched
//   Merges two lane FIFOs into one output stream, popping lane 0 then lane 1
//   in strict alternation. Waits for both lanes to hold data before starting
//   a pair, stalls on lane skew or downstream backpressure, and only leaves
//   the run states on a pair boundary so lane order never slips.
//
//   Ports:
//     clk_2f       : output-rate clock
//     reset_L      : asynchronous active-low reset
//     enable       : 1 = run, 0 = finish the current pair then idle
//     bus (master) : lane heads/pops and registered data_out/valid_out
//     active       : scheduler is in RUN0 or RUN1
//     word_cnt     : words loaded into data_out since reset (wraps)
//     underrun_cnt : saturating count of skew-stall cycles
//
//   Optional feature: define UNSTRIPE_UNDERRUN_CNT_EN to build the skew-stall
//   counter; otherwise underrun_cnt is tied to zero.
// ---------------------------------------------------------------------------
module unstripe_lane_sched
  import unstripe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                  clk_2f,
  input  logic                  reset_L,
  input  logic                  enable,
  unstripe_lane_sched_if.master bus,
  output logic                  active,
  output logic [CNT_W-1:0]      word_cnt,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  sched_state_e      state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              slot_free;
  logic              pop0, pop1;
  logic              load;
  logic              skew_stall;

  // The output register can take a new word when it is empty or its
  // current word is being accepted this cycle.
  assign slot_free = !valid_q || bus.out_ready;

  // Next-state / pop decode.
  always_comb begin
    state_d    = state_q;
    pop0       = 1'b0;
    pop1       = 1'b0;
    skew_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = ALIGN;
      end
      ALIGN: begin
        // Start a pair only when both lanes can supply their word.
        if (!enable)                                 state_d = IDLE;
        else if (!bus.lane0_empty && !bus.lane1_empty) state_d = RUN0;
      end
      RUN0: begin
        // RUN0 is the only pair boundary, so enable is honoured here
        // before a new pair is started.
        if (!enable) begin
          state_d = IDLE;
        end else if (!bus.lane0_empty && slot_free) begin
          pop0    = 1'b1;
          state_d = RUN1;
        end else if (bus.lane0_empty && bus.lane1_empty) begin
          state_d = ALIGN;
        end else if (bus.lane0_empty) begin
          skew_stall = 1'b1;
        end
      end
      RUN1: begin
        // Never abandon a started pair: wait here until lane 1 delivers.
        if (!bus.lane1_empty && slot_free) begin
          pop1    = 1'b1;
          state_d = enable ? RUN0 : IDLE;
        end else if (bus.lane1_empty && !bus.lane0_empty) begin
          skew_stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load = pop0 | pop1;

  // Output register and word counter.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (load) begin
      data_d  = pop0 ? bus.lane0_data : bus.lane1_data;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 1'b1;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= STATE_RST;
      data_q  <= '0;
      valid_q <= VALID_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef UNSTRIPE_UNDERRUN_CNT_EN
  logic [UNDERRUN_W-1:0] underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if (skew_stall) underrun_d = sat_inc(underrun_q);
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) underrun_q <= '0;
    else          underrun_q <= underrun_d;
  end

  assign underrun_cnt = underrun_q;
`else
  logic unused_skew_stall;
  assign unused_skew_stall = skew_stall;
  assign underrun_cnt      = '0;
`endif

  assign bus.lane0_pop = pop0;
  assign bus.lane1_pop = pop1;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign active        = (state_q == RUN0) || (state_q == RUN1);
  assign word_cnt      = cnt_q;

endmodule
